// File: rtl/regfile_seq.sv
// Operand-fetch sequencer: serialises one or two reads through a single synchronous
// register-file read port, forwards same-edge writebacks, and passes writes through.
module regfile_seq #(
    parameter int addr_width = 4,
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [addr_width-1:0] req_ra,
    input  logic [addr_width-1:0] req_rb,
    input  logic                  req_two,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [data_width-1:0] rsp_a,
    output logic [data_width-1:0] rsp_b,
    input  logic                  wb_valid,
    input  logic [addr_width-1:0] wb_adr,
    input  logic [data_width-1:0] wb_data,
    output logic                  rf_we,
    output logic [addr_width-1:0] rf_wadr,
    output logic [data_width-1:0] rf_din,
    output logic [addr_width-1:0] rf_radr,
    input  logic [data_width-1:0] rf_dout
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CAP_A,
        CAP_B,
        RESP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [addr_width-1:0] ra_q;
    logic [addr_width-1:0] rb_q;
    logic                  two_q;
    logic                  fwd_a;
    logic                  fwd_b;
    logic [data_width-1:0] fwd_data_a;
    logic [data_width-1:0] fwd_data_b;
    logic                  hit_a;
    logic                  hit_b;

    assign rf_we   = wb_valid & ~reset;
    assign rf_wadr = wb_adr;
    assign rf_din  = wb_data;

    // A write landing on the read edge must win over the stale value the port returns.
    assign hit_a = wb_valid && (wb_adr == ra_q);
    assign hit_b = wb_valid && (wb_adr == rb_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rf_radr   = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = RD_A;
                end
            end
            RD_A: begin
                rf_radr   = ra_q;
                state_nxt = two_q ? RD_B : CAP_A;
            end
            RD_B: begin
                rf_radr   = rb_q;
                state_nxt = CAP_B;
            end
            CAP_A:   state_nxt = RESP;
            CAP_B:   state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields and forward payloads are qualified by state, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            ra_q  <= req_ra;
            rb_q  <= req_rb;
            two_q <= req_two;
        end
        if (state == RD_A) begin
            fwd_data_a <= wb_data;
        end
        if (state == RD_B) begin
            fwd_data_b <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_a <= 1'b0;
            fwd_b <= 1'b0;
            rsp_a <= '0;
            rsp_b <= '0;
        end else begin
            if (state == RD_A) begin
                fwd_a <= hit_a;
            end
            if (state == RD_B) begin
                fwd_b <= hit_b;
            end
            if (state == RD_B || state == CAP_A) begin
                rsp_a <= fwd_a ? fwd_data_a : rf_dout;
            end
            if (state == CAP_A) begin
                rsp_b <= '0;
            end
            if (state == CAP_B) begin
                rsp_b <= fwd_b ? fwd_data_b : rf_dout;
            end
        end
    end

endmodule

// File: tb/tb_regfile_seq.sv
// Directed bench for regfile_seq with a behavioural register file and a response scoreboard.
module tb_regfile_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_ra;
    logic [3:0]  req_rb;
    logic        req_two;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_a;
    logic [15:0] rsp_b;
    logic        wb_valid;
    logic [3:0]  wb_adr;
    logic [15:0] wb_data;
    logic        rf_we;
    logic [3:0]  rf_wadr;
    logic [15:0] rf_din;
    logic [3:0]  rf_radr;
    logic [15:0] rf_dout = '0;

    logic [15:0] mem [16] = '{default: 16'h0};
    logic [15:0] ref_mem [16] = '{default: 16'h0};

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] b2b_ra [4] = '{4'd1, 4'd4, 4'd3, 4'd0};
    logic [3:0] b2b_rb [4] = '{4'd2, 4'd6, 4'd5, 4'd7};

    always #5 clk = ~clk;

    // Register file: synchronous write, registered read returning the pre-write value.
    always @(posedge clk) begin
        if (rf_we) mem[rf_wadr] <= rf_din;
        rf_dout <= mem[rf_radr];
    end

    regfile_seq dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ra(req_ra), .req_rb(req_rb), .req_two(req_two),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_a(rsp_a), .rsp_b(rsp_b),
        .wb_valid(wb_valid), .wb_adr(wb_adr), .wb_data(wb_data),
        .rf_we(rf_we), .rf_wadr(rf_wadr), .rf_din(rf_din),
        .rf_radr(rf_radr), .rf_dout(rf_dout)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [15:0] data);
        wb_valid = 1'b1;
        wb_adr   = adr;
        wb_data  = data;
        ref_mem[adr] = data;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic issue(input logic [3:0] ra, input logic [3:0] rb, input logic two,
                         input logic [15:0] ea, input logic [15:0] eb);
        exp_t e;
        check("req_ready_before_issue", 16'(req_ready), 16'd1);
        req_valid = 1'b1;
        req_ra    = ra;
        req_rb    = rb;
        req_two   = two;
        e.a = ea;
        e.b = eb;
        sb.push_back(e);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic collect(input int n, input string tag);
        int   cnt;
        exp_t e;
        cnt = 0;
        while (!rsp_valid && cnt < 10) begin
            tick();
            cnt++;
        end
        check({tag, "_latency"}, 16'(cnt), 16'(n));
        if (rsp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_rsp_a"}, rsp_a, e.a);
            check({tag, "_rsp_b"}, rsp_b, e.b);
        end
    endtask

    task automatic finish_rsp(input string tag);
        tick();
        check({tag, "_req_ready_after"}, 16'(req_ready), 16'd1);
        check({tag, "_rsp_valid_after"}, 16'(rsp_valid), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   acc_cnt;
        int   last_acc;
        bit   accept_now;
        int   cyc;
        int   wadr;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_ra    = '0;
        req_rb    = '0;
        req_two   = 1'b0;
        rsp_ready = 1'b1;
        wb_valid  = 1'b1;
        wb_adr    = 4'd0;
        wb_data   = 16'hDEAD;
        tick();
        tick();
        check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        check("rst_rsp_a", rsp_a, 16'h0);
        check("rst_rsp_b", rsp_b, 16'h0);
        check("rst_rf_we", 16'(rf_we), 16'd0);
        reset    = 1'b0;
        wb_valid = 1'b0;
        #1;
        check("rst_req_ready", 16'(req_ready), 16'd1);

        // Pass-through visibility and register preload.
        wb_valid = 1'b1;
        wb_adr   = 4'd9;
        wb_data  = 16'h5A5A;
        #1;
        check("pass_rf_we", 16'(rf_we), 16'd1);
        check("pass_rf_wadr", 16'(rf_wadr), 16'd9);
        check("pass_rf_din", rf_din, 16'h5A5A);
        ref_mem[9] = 16'h5A5A;
        tick();
        wb_valid = 1'b0;
        wr(4'd3, 16'h1234);
        wr(4'd7, 16'hBEEF);
        wr(4'd1, 16'h1111);
        wr(4'd2, 16'h2222);
        wr(4'd4, 16'h4444);
        wr(4'd6, 16'h6666);

        issue(4'd3, 4'd7, 1'b1, 16'h1234, 16'hBEEF);
        collect(3, "two_op");
        finish_rsp("two_op");

        issue(4'd7, 4'd3, 1'b0, 16'hBEEF, 16'h0000);
        collect(2, "one_op");
        finish_rsp("one_op");

        // Write to ra during RD_A must be forwarded.
        wr(4'd5, 16'h0001);
        issue(4'd5, 4'd7, 1'b1, 16'h00AA, 16'hBEEF);
        wb_valid = 1'b1; wb_adr = 4'd5; wb_data = 16'h00AA; ref_mem[5] = 16'h00AA;
        tick();
        wb_valid = 1'b0;
        collect(2, "haz_rd_a");
        finish_rsp("haz_rd_a");

        // Same write one cycle later: A keeps old value, B (same reg) gets the new one.
        wr(4'd5, 16'h0001);
        issue(4'd5, 4'd5, 1'b1, 16'h0001, 16'h00AA);
        tick();
        wb_valid = 1'b1; wb_adr = 4'd5; wb_data = 16'h00AA; ref_mem[5] = 16'h00AA;
        tick();
        wb_valid = 1'b0;
        collect(1, "haz_rd_b");
        finish_rsp("haz_rd_b");

        // Backpressure with writes to the fetched registers.
        rsp_ready = 1'b0;
        issue(4'd3, 4'd7, 1'b1, 16'h1234, 16'hBEEF);
        collect(3, "bp");
        for (int i = 0; i < 10; i++) begin
            wb_valid = 1'b1;
            wb_adr   = (i % 2 == 0) ? 4'd3 : 4'd7;
            wb_data  = 16'hFFFF;
            ref_mem[wb_adr] = 16'hFFFF;
            tick();
            check("bp_rsp_valid", 16'(rsp_valid), 16'd1);
            check("bp_rsp_a", rsp_a, 16'h1234);
            check("bp_rsp_b", rsp_b, 16'hBEEF);
            check("bp_req_ready", 16'(req_ready), 16'd0);
        end
        wb_valid  = 1'b0;
        rsp_ready = 1'b1;
        finish_rsp("bp");

        // Asynchronous reset in the middle of RD_B.
        issue(4'd3, 4'd7, 1'b1, 16'hFFFF, 16'hFFFF);
        void'(sb.pop_back());
        tick();
        #2;
        reset    = 1'b1;
        wb_valid = 1'b1;
        wb_adr   = 4'd2;
        wb_data  = 16'hDEAD;
        #1;
        check("arst_rsp_valid", 16'(rsp_valid), 16'd0);
        check("arst_rsp_a", rsp_a, 16'h0);
        check("arst_rsp_b", rsp_b, 16'h0);
        check("arst_rf_we", 16'(rf_we), 16'd0);
        check("arst_req_ready", 16'(req_ready), 16'd1);
        tick();
        reset    = 1'b0;
        wb_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("arst_no_rsp", 16'(rsp_valid), 16'd0);
        end
        issue(4'd3, 4'd7, 1'b1, 16'hFFFF, 16'hFFFF);
        collect(3, "post_rst");
        finish_rsp("post_rst");

        // Back-to-back requests with a continuous write stream to r8..r15.
        acc_cnt   = 0;
        last_acc  = -1;
        req_valid = 1'b1;
        req_ra    = b2b_ra[0];
        req_rb    = b2b_rb[0];
        req_two   = 1'b1;
        for (cyc = 0; cyc < 80 && !(acc_cnt == 4 && sb.size() == 0); cyc++) begin
            if (rsp_valid) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("b2b_rsp_a", rsp_a, e.a);
                    check("b2b_rsp_b", rsp_b, e.b);
                end else begin
                    check("b2b_unexpected_rsp", 16'(rsp_valid), 16'd0);
                end
            end
            accept_now = req_valid && req_ready;
            if (accept_now) begin
                if (last_acc >= 0) check("b2b_spacing", 16'(cyc - last_acc), 16'd5);
                last_acc = cyc;
                e.a = ref_mem[req_ra];
                e.b = ref_mem[req_rb];
                sb.push_back(e);
                acc_cnt++;
            end
            wadr     = 8 + (cyc % 8);
            wb_valid = 1'b1;
            wb_adr   = 4'(wadr);
            wb_data  = 16'($urandom);
            ref_mem[wadr] = wb_data;
            tick();
            if (accept_now) begin
                if (acc_cnt < 4) begin
                    req_ra = b2b_ra[acc_cnt];
                    req_rb = b2b_rb[acc_cnt];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        wb_valid = 1'b0;
        check("b2b_accepts", 16'(acc_cnt), 16'd4);
        check("b2b_sb_empty", 16'(sb.size()), 16'd0);

        tick();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("rf_mem_%0d", i), mem[i], ref_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
